// File: rtl/led_pwm_seq.sv
// led_pwm_seq: NUM_CH-channel PWM LED sequencer (off/static/blink/breathe); new config applied only at frame ends.
// Latency pwm_cnt->pwm_out: 1 cycle, or 2 cycles when LED_PWM_GAMMA_EN is defined (square-law gamma on duty/level).
// Backpressure: one-entry pending slot; cfg_ready stays low from the transfer until the cycle after the frame-end apply.
module led_pwm_seq #(
    parameter int NUM_CH     = 3,
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [1:0]            cfg_mode,
    input  logic [PWM_BITS-1:0]   cfg_duty,
    input  logic [PRESC_BITS-1:0] presc_max,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic                  frame_tick,
    output logic                  step_tick
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;
    localparam logic [PWM_BITS-1:0] CNT_PRE  = CNT_LAST - PWM_BITS'(1);

    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [PRESC_BITS-1:0] presc_cnt;

    logic                  pend_vld;
    logic [CH_W-1:0]       pend_ch;
    mode_e                 pend_mode;
    logic [PWM_BITS-1:0]   pend_duty;

    mode_e                 mode_q   [NUM_CH];
    logic [PWM_BITS-1:0]   duty_q   [NUM_CH];
    logic [PWM_BITS-1:0]   level_q  [NUM_CH];
    logic                  phase_q  [NUM_CH];
    logic                  dir_dn_q [NUM_CH];

    logic [PWM_BITS-1:0]   target   [NUM_CH];

    logic xfer;
    logic apply;
    logic presc_hit;

    // frame_tick is high exactly on the pwm_cnt==max cycle, so it doubles as the frame-end strobe.
    assign presc_hit = (presc_cnt == presc_max);
    assign step_tick = frame_tick && presc_hit;
    assign xfer      = cfg_valid && cfg_ready;
    assign apply     = pend_vld && frame_tick;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pwm_cnt    <= '0;
            presc_cnt  <= '0;
            frame_tick <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
            frame_tick <= (pwm_cnt == CNT_PRE);
            if (frame_tick) begin
                if (presc_hit) begin
                    presc_cnt <= '0;
                end else begin
                    presc_cnt <= presc_cnt + PRESC_BITS'(1);
                end
            end
        end
    end

    // A transfer can only happen while the slot is empty, so it never collides with an apply.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_vld  <= 1'b0;
            pend_ch   <= '0;
            pend_mode <= MODE_OFF;
            pend_duty <= '0;
            cfg_ready <= 1'b0;
        end else if (xfer) begin
            pend_vld  <= 1'b1;
            pend_ch   <= cfg_ch;
            pend_mode <= mode_e'(cfg_mode);
            pend_duty <= cfg_duty;
            cfg_ready <= 1'b0;
        end else if (apply) begin
            pend_vld  <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            cfg_ready <= !pend_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]   <= MODE_OFF;
                duty_q[i]   <= '0;
                level_q[i]  <= '0;
                phase_q[i]  <= 1'b0;
                dir_dn_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (apply && (32'(pend_ch) == i)) begin
                    mode_q[i]   <= pend_mode;
                    duty_q[i]   <= pend_duty;
                    level_q[i]  <= '0;
                    phase_q[i]  <= 1'b0;
                    dir_dn_q[i] <= 1'b0;
                end else if (step_tick) begin
                    case (mode_q[i])
                        MODE_BLINK: phase_q[i] <= !phase_q[i];
                        MODE_BREATHE: begin
                            // Triangle between 0 and duty; turning points reverse and move in one step.
                            if (!dir_dn_q[i]) begin
                                if (level_q[i] < duty_q[i]) begin
                                    level_q[i] <= level_q[i] + PWM_BITS'(1);
                                end else begin
                                    dir_dn_q[i] <= 1'b1;
                                    if (level_q[i] != '0) level_q[i] <= level_q[i] - PWM_BITS'(1);
                                end
                            end else begin
                                if (level_q[i] != '0) begin
                                    level_q[i] <= level_q[i] - PWM_BITS'(1);
                                end else begin
                                    dir_dn_q[i] <= 1'b0;
                                    if (duty_q[i] != '0) level_q[i] <= level_q[i] + PWM_BITS'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            target[i] = '0;
            case (mode_q[i])
                MODE_STATIC:  target[i] = duty_q[i];
                MODE_BLINK:   target[i] = phase_q[i] ? duty_q[i] : '0;
                MODE_BREATHE: target[i] = level_q[i];
                default:      target[i] = '0;
            endcase
        end
    end

`ifdef LED_PWM_GAMMA_EN
    logic [PWM_BITS-1:0] cnt_d;
    logic [PWM_BITS-1:0] eff_q [NUM_CH];

    // Counter is delayed alongside the squared value so the compare stays frame-aligned.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_d   <= '0;
            pwm_out <= '0;
            for (int i = 0; i < NUM_CH; i++) eff_q[i] <= '0;
        end else begin
            cnt_d <= pwm_cnt;
            for (int i = 0; i < NUM_CH; i++) begin
                eff_q[i]   <= PWM_BITS'(((2*PWM_BITS)'(target[i]) * (2*PWM_BITS)'(target[i])) >> PWM_BITS);
                pwm_out[i] <= (cnt_d < eff_q[i]);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= (pwm_cnt < target[i]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_led_pwm_seq.sv
// Scoreboard bench for led_pwm_seq: a frame/step-level reference model predicts every cycle's outputs.
module tb_led_pwm_seq;
    localparam int NUM_CH     = 3;
    localparam int PWM_BITS   = 8;
    localparam int PRESC_BITS = 16;
    localparam int FRAME      = 256;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  cfg_valid = 1'b0;
    logic                  cfg_ready;
    logic [1:0]            cfg_ch = '0;
    logic [1:0]            cfg_mode = '0;
    logic [PWM_BITS-1:0]   cfg_duty = '0;
    logic [PRESC_BITS-1:0] presc_max = '0;
    logic [NUM_CH-1:0]     pwm_out;
    logic                  frame_tick;
    logic                  step_tick;

    led_pwm_seq #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PRESC_BITS(PRESC_BITS)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
        .presc_max(presc_max),
        .pwm_out(pwm_out), .frame_tick(frame_tick), .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH-1:0] pwm;
        logic              ft;
        logic              st;
        logic              rdy;
    } exp_t;

    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    string phase = "reset";

    // Reference model: cycles since reset, prescaler count, and per channel the config plus steps since apply.
    int   m_n, m_presc;
    int   m_mode [NUM_CH];
    int   m_duty [NUM_CH];
    int   m_k    [NUM_CH];
    bit   m_pend, m_ready;
    int   p_ch, p_mode, p_duty;
    int   pc, applied;
    bit   stepped, xfer;
    exp_t e;

    function automatic int tri_lvl(int k, int d);
        int m;
        if (d == 0) return 0;
        m = k % (2 * d);
        return (m <= d) ? m : 2 * d - m;
    endfunction

    function automatic int thr(int c);
        case (m_mode[c])
            1:       return m_duty[c];
            2:       return (m_k[c] % 2 == 1) ? m_duty[c] : 0;
            3:       return tri_lvl(m_k[c], m_duty[c]);
            default: return 0;
        endcase
    endfunction

    initial begin : model
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                m_n = 0; m_presc = 0; m_pend = 0; m_ready = 0;
                for (int c = 0; c < NUM_CH; c++) begin
                    m_mode[c] = 0; m_duty[c] = 0; m_k[c] = 0;
                end
                e = '0;
            end else begin
                pc = m_n % FRAME;
                for (int c = 0; c < NUM_CH; c++) e.pwm[c] = (pc < thr(c));
                xfer = cfg_valid && m_ready;
                if (pc == FRAME - 1) begin
                    stepped = (m_presc == int'(presc_max));
                    m_presc = stepped ? 0 : m_presc + 1;
                    applied = -1;
                    if (m_pend && p_ch < NUM_CH) begin
                        m_mode[p_ch] = p_mode;
                        m_duty[p_ch] = p_duty;
                        m_k[p_ch]    = 0;
                        applied      = p_ch;
                    end
                    if (stepped) begin
                        for (int c = 0; c < NUM_CH; c++) if (c != applied) m_k[c]++;
                    end
                    m_pend = 0;
                end
                if (xfer) begin
                    m_pend = 1;
                    p_ch   = int'(cfg_ch);
                    p_mode = int'(cfg_mode);
                    p_duty = int'(cfg_duty);
                end
                m_ready = !m_pend;
                m_n++;
                e.ft  = (m_n % FRAME == FRAME - 1);
                e.st  = e.ft && (m_presc == int'(presc_max));
                e.rdy = m_ready;
            end
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t act, want;
        forever begin
            @(posedge clk);
            #2;
            act = '{pwm: pwm_out, ft: frame_tick, st: step_tick, rdy: cfg_ready};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard: no expectation queued at t=%0t (got pwm=%b)", phase, $time, act.pwm);
            end else begin
                want = exp_q.pop_front();
                if (act !== want) begin
                    errors++;
                    $display("FAIL %s outputs t=%0t: got pwm=%b ft=%b st=%b rdy=%b, expected pwm=%b ft=%b st=%b rdy=%b",
                             phase, $time, act.pwm, act.ft, act.st, act.rdy, want.pwm, want.ft, want.st, want.rdy);
                end
            end
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_cfg(input int ch, input int mode, input int duty, input bit at_fe);
        bit got;
        got = 0;
        @(negedge clk);
        if (at_fe) begin
            for (int i = 0; i < 3 * FRAME && !cfg_ready; i++) @(negedge clk);
            for (int i = 0; i < 2 * FRAME && !frame_tick; i++) @(negedge clk);
        end
        cfg_ch    = 2'(ch);
        cfg_mode  = 2'(mode);
        cfg_duty  = PWM_BITS'(duty);
        cfg_valid = 1'b1;
        for (int i = 0; i < 3 * FRAME && !got; i++) begin
            got = cfg_ready;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s handshake: cfg_ready stayed %b for %0d cycles, required 1", phase, cfg_ready, 3 * FRAME);
        end
    endtask

    initial begin : stimulus
        rstn = 1'b0; cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'd1; cfg_duty = 8'd99;
        repeat (5) @(negedge clk);
        rstn = 1'b1; cfg_valid = 1'b0;
        run(300);

        phase = "static"; presc_max = 0;
        run(40);
        send_cfg(1, 1, 64, 0);
        run(3 * FRAME);

        phase = "blink"; presc_max = 1;
        send_cfg(0, 2, 255, 0);
        run(6 * FRAME);

        phase = "breathe"; presc_max = 0;
        send_cfg(2, 3, 3, 0);
        run(9 * FRAME);

        phase = "cfg_on_frame_end";
        send_cfg(1, 1, 200, 1);
        run(2 * FRAME);

        phase = "bad_channel";
        send_cfg(3, 3, 128, 0);
        run(2 * FRAME);

        phase = "reapply_breathe";
        run(100);
        send_cfg(2, 3, 3, 0);
        run(4 * FRAME);

        phase = "duty_zero";
        send_cfg(0, 1, 0, 0);
        run(FRAME + 10);

        phase = "random";
        for (int r = 0; r < 12; r++) begin
            int d;
            case ($urandom_range(0, 3))
                0:       d = 0;
                1:       d = 255;
                2:       d = 1;
                default: d = int'($urandom_range(0, 255));
            endcase
            presc_max = PRESC_BITS'($urandom_range(0, 2));
            send_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d, 1'($urandom_range(0, 1)));
            run(int'($urandom_range(0, 400)));
        end

        phase = "midop_reset";
        send_cfg(0, 3, 200, 0);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        run(2 * FRAME + 20);

        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
